pcie_hcmd_slot_mgt: RTL and testbench

PCIE_HCMD_SLOT_MGT -- requirements
Module: pcie_hcmd_slot_mgt

---
 rtl/pcie_hcmd_slot_mgt_pkg.sv | 18 +
 rtl/pcie_hcmd_slot_mgt_if.sv | 32 +++
 rtl/pcie_hcmd_slot_ram.sv | 30 +++
 rtl/pcie_hcmd_slot_mgt.sv | 198 +++++++++++++++++++
 tb/tb_pcie_hcmd_slot_mgt.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_hcmd_slot_mgt_pkg.sv
// rtl/pcie_hcmd_slot_mgt_pkg.sv - shared hcmd slot constants, state encoding and helpers
package pcie_hcmd_slot_mgt_pkg;

    localparam int HCMD_SLOT_TAG_WIDTH = 10;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_FETCH   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_READY   = 2'd3
    } hcmd_slot_state_t;

    // Number of slots addressable by a tag of the given width.
    function automatic int hcmd_slot_num(input int tag_width);
        return 1 << tag_width;
    endfunction

endpackage

// File: rtl/pcie_hcmd_slot_mgt_if.sv
// rtl/pcie_hcmd_slot_mgt_if.sv - slot allocate/free handshake bundle
interface pcie_hcmd_slot_mgt_if #(
    parameter int P_SLOT_TAG_WIDTH = pcie_hcmd_slot_mgt_pkg::HCMD_SLOT_TAG_WIDTH
);
    logic                        hcmd_slot_rdy;
    logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_tag;
    logic                        hcmd_slot_alloc_en;
    logic                        hcmd_slot_free_en;
    logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_free_tag;
    logic [P_SLOT_TAG_WIDTH:0]   hcmd_slot_free_cnt;
    logic                        hcmd_slot_err;

    modport master (
        input  hcmd_slot_rdy,
        input  hcmd_slot_tag,
        input  hcmd_slot_free_cnt,
        input  hcmd_slot_err,
        output hcmd_slot_alloc_en,
        output hcmd_slot_free_en,
        output hcmd_slot_free_tag
    );

    modport slave (
        output hcmd_slot_rdy,
        output hcmd_slot_tag,
        output hcmd_slot_free_cnt,
        output hcmd_slot_err,
        input  hcmd_slot_alloc_en,
        input  hcmd_slot_free_en,
        input  hcmd_slot_free_tag
    );
endinterface

// File: rtl/pcie_hcmd_slot_ram.sv
// rtl/pcie_hcmd_slot_ram.sv - simple dual-port free-list RAM with registered read
module pcie_hcmd_slot_ram #(
    parameter int P_SLOT_TAG_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [P_SLOT_TAG_WIDTH-1:0] wr_addr,
    input  logic [P_SLOT_TAG_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [P_SLOT_TAG_WIDTH-1:0] rd_addr,
    output logic [P_SLOT_TAG_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << P_SLOT_TAG_WIDTH;

    logic [P_SLOT_TAG_WIDTH-1:0] mem [0:DEPTH-1];

    // Write port; storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/pcie_hcmd_slot_mgt.sv
// rtl/pcie_hcmd_slot_mgt.sv - host command slot tag allocator with circular free list
module pcie_hcmd_slot_mgt
    import pcie_hcmd_slot_mgt_pkg::*;
#(
    parameter int P_SLOT_TAG_WIDTH = HCMD_SLOT_TAG_WIDTH
) (
    input  logic                 pcie_user_clk,
    input  logic                 pcie_user_rst_n,
    pcie_hcmd_slot_mgt_if.slave  slot_if
);
    localparam int                      W        = P_SLOT_TAG_WIDTH;
    localparam int                      N        = hcmd_slot_num(W);
    localparam logic [W:0]              SLOT_NUM = (W+1)'(N);
    localparam logic [W:0]              PTR_ONE  = (W+1)'(1);
    localparam logic [W-1:0]            TAG_ONE  = W'(1);
    localparam logic [W-1:0]            TAG_LAST = W'(N - 1);

    hcmd_slot_state_t state, state_next;

    logic [W-1:0] init_cnt;
    logic [W:0]   head;
    logic [W:0]   tail;
    logic [N-1:0] busy;
    logic [N-1:0] busy_next;
    logic         rdy;
    logic [W-1:0] tag;
    logic [W:0]   free_cnt;
    logic         err;

    logic         list_empty;
    logic         init_last;
    logic         alloc_acc;
    logic         alloc_bad;
    logic         free_acc;
    logic         free_bad;
    logic         rd_issue;
    logic         ram_we;
    logic [W-1:0] ram_waddr;
    logic [W-1:0] ram_wdata;
    logic [W-1:0] ram_rdata;

    // Head and tail equal including the wrap bit means nothing is left to fetch.
    assign list_empty = (head == tail);
    assign init_last  = (init_cnt == TAG_LAST);
    assign alloc_acc  = slot_if.hcmd_slot_alloc_en & rdy;
    assign alloc_bad  = slot_if.hcmd_slot_alloc_en & ~rdy;
    // A free is only taken for a busy tag; this also blocks overflowing a full list.
    assign free_acc   = slot_if.hcmd_slot_free_en & (state != S_INIT) &
                        busy[slot_if.hcmd_slot_free_tag];
    assign free_bad   = slot_if.hcmd_slot_free_en & ~free_acc;

    pcie_hcmd_slot_ram #(
        .P_SLOT_TAG_WIDTH (W)
    ) u_slot_ram (
        .clk     (pcie_user_clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (rd_issue),
        .rd_addr (head[W-1:0]),
        .rd_data (ram_rdata)
    );

    // State register.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, free-list write port selection and head read request.
    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        ram_we     = free_acc;
        ram_waddr  = tail[W-1:0];
        ram_wdata  = slot_if.hcmd_slot_free_tag;
        case (state)
            S_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt;
                ram_wdata = init_cnt;
                if (init_last) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!list_empty) begin
                    rd_issue   = 1'b1;
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                state_next = S_READY;
            end
            S_READY: begin
                if (alloc_acc) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // Busy bitmap update: mark the handed-out tag, clear the returned one.
    always_comb begin
        busy_next = busy;
        if (alloc_acc) begin
            busy_next[tag] = 1'b1;
        end
        if (free_acc) begin
            busy_next[slot_if.hcmd_slot_free_tag] = 1'b0;
        end
    end

    // Init counter walks every entry once after reset.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + TAG_ONE;
        end
    end

    // Head advances on each fetch, tail on each returned tag; init leaves the list full.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (rd_issue) begin
                head <= head + PTR_ONE;
            end
            if (state == S_INIT) begin
                if (init_last) begin
                    tail <= SLOT_NUM;
                end
            end else if (free_acc) begin
                tail <= tail + PTR_ONE;
            end
        end
    end

    // Busy bitmap register.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Presented tag is loaded from the RAM read and held while ready.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            rdy <= 1'b0;
            tag <= '0;
        end else begin
            rdy <= (state_next == S_READY);
            if (state == S_RD_WAIT) begin
                tag <= ram_rdata;
            end
        end
    end

    // Free tag count including the presented or in-flight tag.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            free_cnt <= '0;
        end else if (state == S_INIT) begin
            if (init_last) begin
                free_cnt <= SLOT_NUM;
            end
        end else if (alloc_acc && !free_acc) begin
            free_cnt <= free_cnt - PTR_ONE;
        end else if (free_acc && !alloc_acc) begin
            free_cnt <= free_cnt + PTR_ONE;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            err <= 1'b0;
        end else if (alloc_bad || free_bad) begin
            err <= 1'b1;
        end
    end

    assign slot_if.hcmd_slot_rdy      = rdy;
    assign slot_if.hcmd_slot_tag      = tag;
    assign slot_if.hcmd_slot_free_cnt = free_cnt;
    assign slot_if.hcmd_slot_err      = err;
endmodule

// File: tb/tb_pcie_hcmd_slot_mgt.sv
// tb/tb_pcie_hcmd_slot_mgt.sv - scoreboard bench for the slot tag allocator
module tb_pcie_hcmd_slot_mgt;
    localparam int W = 4;
    localparam int N = 16;

    localparam int MP_INIT  = 0;
    localparam int MP_FETCH = 1;
    localparam int MP_RDW   = 2;
    localparam int MP_READY = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pcie_hcmd_slot_mgt_if #(.P_SLOT_TAG_WIDTH(W)) slot_if ();

    pcie_hcmd_slot_mgt #(
        .P_SLOT_TAG_WIDTH (W)
    ) dut (
        .pcie_user_clk   (clk),
        .pcie_user_rst_n (rst_n),
        .slot_if         (slot_if)
    );

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_init_left;
    int m_q[$];
    bit m_busy[N];
    bit m_err;
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = MP_INIT;
        m_init_left = N;
        m_q.delete();
        for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        slot_if.hcmd_slot_alloc_en = 1'b0;
        slot_if.hcmd_slot_free_en  = 1'b0;
        slot_if.hcmd_slot_free_tag = '0;
        #1;
        chk("rst_rdy", int'(slot_if.hcmd_slot_rdy), 0);
        chk("rst_tag", int'(slot_if.hcmd_slot_tag), 0);
        chk("rst_free_cnt", int'(slot_if.hcmd_slot_free_cnt), 0);
        chk("rst_err", int'(slot_if.hcmd_slot_err), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input bit a, input bit f, input int ft);
        int  sz;
        int  t;
        bit  acc_a;
        bit  acc_f;
        @(negedge clk);
        chk("rdy", int'(slot_if.hcmd_slot_rdy), int'(m_phase == MP_READY));
        chk("free_cnt", int'(slot_if.hcmd_slot_free_cnt), (m_phase == MP_INIT) ? 0 : m_q.size());
        chk("err", int'(slot_if.hcmd_slot_err), int'(m_err));
        if (m_phase == MP_READY) chk("tag", int'(slot_if.hcmd_slot_tag), m_q[0]);
        slot_if.hcmd_slot_alloc_en = a;
        slot_if.hcmd_slot_free_en  = f;
        slot_if.hcmd_slot_free_tag = W'(ft);
        sz    = m_q.size();
        acc_a = a && (m_phase == MP_READY);
        acc_f = f && (m_phase != MP_INIT) && m_busy[ft];
        if ((a && !acc_a) || (f && !acc_f)) m_err = 1'b1;
        if (acc_a) begin
            t = m_q.pop_front();
            m_busy[t] = 1'b1;
            exp_q.push_back(t);
        end
        if (acc_f) begin
            m_busy[ft] = 1'b0;
            m_q.push_back(ft);
        end
        case (m_phase)
            MP_INIT: begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int k = 0; k < N; k++) m_q.push_back(k);
                    m_phase = MP_FETCH;
                end
            end
            MP_FETCH: if (sz > 0) m_phase = MP_RDW;
            MP_RDW:   m_phase = MP_READY;
            default:  if (acc_a) m_phase = MP_FETCH;
        endcase
        @(posedge clk);
        #1;
        slot_if.hcmd_slot_alloc_en = 1'b0;
        slot_if.hcmd_slot_free_en  = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (m_phase != MP_READY && n < 40) begin
            step(0, 0, 0);
            n++;
        end
        chk("ready_reached", int'(slot_if.hcmd_slot_rdy), 1);
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            wait_ready();
            step(1, 0, 0);
        end
    endtask

    // Monitor: every accepted allocation must hand out the next scoreboard tag.
    initial begin
        int t;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && slot_if.hcmd_slot_rdy && slot_if.hcmd_slot_alloc_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL alloc_unexpected actual tag %0d expected none", slot_if.hcmd_slot_tag);
                end else begin
                    t = exp_q.pop_front();
                    chk("alloc_tag", int'(slot_if.hcmd_slot_tag), t);
                end
            end
        end
    end

    initial begin
        slot_if.hcmd_slot_alloc_en = 1'b0;
        slot_if.hcmd_slot_free_en  = 1'b0;
        slot_if.hcmd_slot_free_tag = '0;
        model_reset();
        do_reset();

        repeat (17) step(0, 0, 0);
        chk("init_rdy_c18", int'(slot_if.hcmd_slot_rdy), 0);
        step(0, 0, 0);
        chk("init_rdy_c19", int'(slot_if.hcmd_slot_rdy), 1);
        chk("init_tag", int'(slot_if.hcmd_slot_tag), 0);
        chk("init_free_cnt", int'(slot_if.hcmd_slot_free_cnt), 16);
        chk("init_err", int'(slot_if.hcmd_slot_err), 0);

        alloc_n(16);
        chk("drain_free_cnt", int'(slot_if.hcmd_slot_free_cnt), 0);
        repeat (4) step(0, 0, 0);
        chk("drain_rdy", int'(slot_if.hcmd_slot_rdy), 0);

        step(0, 1, 7);
        step(0, 1, 3);
        chk("free73_cnt", int'(slot_if.hcmd_slot_free_cnt), 2);
        wait_ready();
        chk("free73_tag7", int'(slot_if.hcmd_slot_tag), 7);
        step(1, 0, 0);
        chk("free73_cnt1", int'(slot_if.hcmd_slot_free_cnt), 1);
        wait_ready();
        chk("free73_tag3", int'(slot_if.hcmd_slot_tag), 3);
        step(1, 0, 0);
        chk("free73_cnt0", int'(slot_if.hcmd_slot_free_cnt), 0);

        step(0, 1, 1);
        step(0, 1, 2);
        step(0, 1, 4);
        wait_ready();
        chk("same_tag1", int'(slot_if.hcmd_slot_tag), 1);
        step(1, 0, 0);
        wait_ready();
        chk("same_tag2", int'(slot_if.hcmd_slot_tag), 2);
        step(1, 1, 5);
        chk("same_cnt", int'(slot_if.hcmd_slot_free_cnt), 2);
        wait_ready();
        chk("same_tag4", int'(slot_if.hcmd_slot_tag), 4);
        step(1, 0, 0);
        wait_ready();
        chk("same_tag5", int'(slot_if.hcmd_slot_tag), 5);
        step(1, 0, 0);

        step(0, 1, 9);
        step(0, 1, 9);
        chk("dfree_err", int'(slot_if.hcmd_slot_err), 1);
        chk("dfree_cnt", int'(slot_if.hcmd_slot_free_cnt), 1);

        do_reset();
        repeat (18) step(0, 0, 0);
        alloc_n(5);
        step(1, 0, 0);
        chk("badalloc_err", int'(slot_if.hcmd_slot_err), 1);
        chk("rdwait_rdy", int'(slot_if.hcmd_slot_rdy), 0);
        do_reset();
        repeat (18) step(0, 0, 0);
        chk("reinit_cnt", int'(slot_if.hcmd_slot_free_cnt), 16);
        chk("reinit_tag", int'(slot_if.hcmd_slot_tag), 0);

        for (int i = 0; i < 600; i++) begin
            bit ra;
            bit rf;
            int rt;
            int bq[$];
            bq.delete();
            ra = (m_phase == MP_READY) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            rf = 1'b0;
            rt = 0;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < N; k++) if (m_busy[k]) bq.push_back(k);
                if (bq.size() > 0) begin
                    rf = 1'b1;
                    rt = bq[$urandom_range(0, bq.size() - 1)];
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                rf = 1'b1;
                rt = $urandom_range(0, N - 1);
            end
            step(ra, rf, rt);
        end

        repeat (5) step(0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
